udp_frame_packer: RTL and testbench

Upstream feeder for the UDP transmit path. Buffers 8-bit samples from the sampling chain in an on-chip ring buffer and starts a UDP frame whenever a full payload is buffered. Each frame carries a 4-byte header (sync, sequence number, latched wave frequency) followed by the payload. The block serves the byte-request handshake of the UDP transmitter and runs entirely in the 125 MHz GMII domain.

---
 rtl/udp_frame_pkg.sv | 14 +
 rtl/frame_ram_dp.sv | 22 ++
 rtl/udp_frame_packer.sv | 164 ++++++++++++++++
 tb/tb_udp_frame_packer.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/udp_frame_pkg.sv
// rtl/udp_frame_pkg.sv - shared state encoding and header constants for the UDP frame packer
package udp_frame_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    SEND      = 2'd2,
    WAIT_DONE = 2'd3
  } pk_state_e;

  localparam int         HDR_LEN      = 4;
  localparam logic [7:0] HDR_SYNC_DEF = 8'hA5;

endpackage

// File: rtl/frame_ram_dp.sv
// rtl/frame_ram_dp.sv - simple dual-port sample RAM, one write port, one registered read port
module frame_ram_dp #(
  parameter int AW = 11,
  parameter int DW = 8
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [0:(1<<AW)-1];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/udp_frame_packer.sv
// rtl/udp_frame_packer.sv - buffers samples and serves header+payload bytes to the UDP transmitter
module udp_frame_packer
  import udp_frame_pkg::*;
#(
  parameter int         PAYLOAD_LEN = 1024,
  parameter int         BUF_AW      = 11,
  parameter logic [7:0] HDR_SYNC    = HDR_SYNC_DEF,
  parameter int         TO_CYCLES   = 65535
) (
  input  logic              clk_125m,
  input  logic              rst,
  input  logic              samp_valid,
  input  logic [7:0]        samp_data,
  input  logic [15:0]       wave_freq,
  input  logic              freq_valid,
  output logic              tx_start_en,
  output logic [15:0]       tx_byte_num,
  input  logic              udp_tx_req,
  output logic [7:0]        udp_tx_data,
  input  logic              udp_tx_done,
  output logic [BUF_AW:0]   fill_cnt,
  output logic [7:0]        ovf_cnt,
  output logic [7:0]        to_cnt
);

  localparam int              TW          = $clog2(TO_CYCLES + 1);
  localparam logic [TW-1:0]   TO_LAST     = TW'(TO_CYCLES - 1);
  localparam logic [BUF_AW:0] PAYLOAD_CNT = (BUF_AW+1)'(PAYLOAD_LEN);
  localparam logic [15:0]     HDR_IDX     = 16'(HDR_LEN);
  localparam logic [15:0]     LAST_IDX    = 16'(PAYLOAD_LEN + HDR_LEN - 1);
  localparam logic [15:0]     FRAME_LEN   = 16'(PAYLOAD_LEN + HDR_LEN);

  pk_state_e         state_q, state_d;
  logic [15:0]       idx_q, idx_d;
  logic [TW-1:0]     tmr_q, tmr_d;
  logic [7:0]        seq_q, seq_d;
  logic [7:0]        to_q, to_d;
  logic [BUF_AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [BUF_AW:0]   fill_q;
  logic [7:0]        ovf_q;
  logic [15:0]       freq_q, hdr_freq_q;
  logic [15:0]       byte_num_q;
  logic [7:0]        hdr_byte_q, hdr_byte_d;
  logic              pay_sel_q, pay_sel_d;
  logic              hdr_cap, rd_en, wr_en;
  logic [7:0]        ram_rdata;

  // The top bit of fill_q alone marks a completely full ring.
  assign wr_en = samp_valid && !fill_q[BUF_AW];

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    tmr_d       = tmr_q;
    seq_d       = seq_q;
    to_d        = to_q;
    tx_start_en = 1'b0;
    hdr_cap     = 1'b0;
    rd_en       = 1'b0;
    hdr_byte_d  = 8'h00;
    pay_sel_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (fill_q >= PAYLOAD_CNT) begin
          state_d = START;
          hdr_cap = 1'b1;
        end
      end
      START: begin
        tx_start_en = 1'b1;
        idx_d       = '0;
        state_d     = SEND;
      end
      SEND: begin
        if (udp_tx_req) begin
          idx_d = idx_q + 16'd1;
          if (idx_q < HDR_IDX) begin
            case (idx_q[1:0])
              2'd0: hdr_byte_d = HDR_SYNC;
              2'd1: hdr_byte_d = seq_q;
              2'd2: hdr_byte_d = hdr_freq_q[15:8];
              2'd3: hdr_byte_d = hdr_freq_q[7:0];
            endcase
          end else begin
            rd_en     = 1'b1;
            pay_sel_d = 1'b1;
          end
          if (idx_q == LAST_IDX) begin
            state_d = WAIT_DONE;
            tmr_d   = '0;
          end
        end
      end
      WAIT_DONE: begin
        if (udp_tx_done) begin
          seq_d   = seq_q + 8'd1;
          state_d = IDLE;
        end else if (tmr_q == TO_LAST) begin
          if (to_q != 8'hFF) to_d = to_q + 8'd1;
          state_d = IDLE;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_125m) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      tmr_q      <= '0;
      seq_q      <= '0;
      to_q       <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fill_q     <= '0;
      ovf_q      <= '0;
      freq_q     <= '0;
      hdr_freq_q <= '0;
      byte_num_q <= '0;
      hdr_byte_q <= '0;
      pay_sel_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      tmr_q      <= tmr_d;
      seq_q      <= seq_d;
      to_q       <= to_d;
      byte_num_q <= FRAME_LEN;
      hdr_byte_q <= hdr_byte_d;
      pay_sel_q  <= pay_sel_d;
      if (freq_valid) freq_q <= wave_freq;
      if (hdr_cap) hdr_freq_q <= freq_q;
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      else if (samp_valid && ovf_q != 8'hFF) ovf_q <= ovf_q + 8'd1;
      if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   fill_q <= fill_q + 1'b1;
        2'b01:   fill_q <= fill_q - 1'b1;
        default: fill_q <= fill_q;
      endcase
    end
  end

  frame_ram_dp #(.AW(BUF_AW), .DW(8)) u_ram (
    .clk_i   (clk_125m),
    .we_i    (wr_en),
    .waddr_i (wr_ptr_q),
    .wdata_i (samp_data),
    .re_i    (rd_en),
    .raddr_i (rd_ptr_q),
    .rdata_o (ram_rdata)
  );

  // Header and payload bytes share one registered stage, so latency is index-independent.
  assign udp_tx_data = pay_sel_q ? ram_rdata : hdr_byte_q;
  assign tx_byte_num = byte_num_q;
  assign fill_cnt    = fill_q;
  assign ovf_cnt     = ovf_q;
  assign to_cnt      = to_q;

endmodule

// File: tb/tb_udp_frame_packer.sv
// tb/tb_udp_frame_packer.sv - scoreboard bench for the UDP frame packer
module tb_udp_frame_packer;

  localparam int PL = 1024;
  localparam int AW = 11;
  localparam int TO = 200;
  localparam int FL = PL + 4;

  logic        clk_125m = 1'b0;
  logic        rst = 1'b1;
  logic        samp_valid = 1'b0;
  logic [7:0]  samp_data = 8'h00;
  logic [15:0] wave_freq = 16'h0000;
  logic        freq_valid = 1'b0;
  logic        udp_tx_req = 1'b0;
  logic        udp_tx_done = 1'b0;
  logic        tx_start_en;
  logic [15:0] tx_byte_num;
  logic [7:0]  udp_tx_data;
  logic [AW:0] fill_cnt;
  logic [7:0]  ovf_cnt;
  logic [7:0]  to_cnt;

  int n_checks = 0;
  int n_pass = 0;

  always #4 clk_125m = ~clk_125m;

  udp_frame_packer #(.PAYLOAD_LEN(PL), .BUF_AW(AW), .HDR_SYNC(8'hA5), .TO_CYCLES(TO)) dut (
    .clk_125m    (clk_125m),
    .rst         (rst),
    .samp_valid  (samp_valid),
    .samp_data   (samp_data),
    .wave_freq   (wave_freq),
    .freq_valid  (freq_valid),
    .tx_start_en (tx_start_en),
    .tx_byte_num (tx_byte_num),
    .udp_tx_req  (udp_tx_req),
    .udp_tx_data (udp_tx_data),
    .udp_tx_done (udp_tx_done),
    .fill_cnt    (fill_cnt),
    .ovf_cnt     (ovf_cnt),
    .to_cnt      (to_cnt)
  );

  // Reference model: buffered samples, expected byte stream, sequence and header frequency.
  logic [7:0]  samp_q[$];
  logic [7:0]  exp_q[$];
  int          m_fill = 0, m_idx = 0, m_tmr = 0, cyc = 0, n_starts = 0;
  bit          m_send = 0, m_wait = 0, acc, start_n = 0;
  logic [7:0]  m_seq = 0;
  logic [15:0] m_freq = 0, m_hdr = 0;

  always @(negedge clk_125m) start_n = tx_start_en;

  always @(posedge clk_125m) begin
    cyc++;
    if (rst) begin
      samp_q.delete();
      exp_q.delete();
      m_fill = 0; m_send = 0; m_wait = 0; m_tmr = 0;
      m_seq = 0; m_freq = 0; m_hdr = 0;
    end else begin
      acc = samp_valid && (m_fill < 2048);
      if (m_wait) begin
        if (udp_tx_done) begin m_seq++; m_wait = 0; end
        else if (m_tmr == TO - 1) m_wait = 0;
        else m_tmr++;
      end
      if (udp_tx_req) begin
        if (m_send) begin
          if (m_idx == 0) exp_q.push_back(8'hA5);
          else if (m_idx == 1) exp_q.push_back(m_seq);
          else if (m_idx == 2) exp_q.push_back(m_hdr[15:8]);
          else if (m_idx == 3) exp_q.push_back(m_hdr[7:0]);
          else begin exp_q.push_back(samp_q.pop_front()); m_fill--; end
          m_idx++;
          if (m_idx == FL) begin m_send = 0; m_wait = 1; m_tmr = 0; end
        end else exp_q.push_back(8'h00);
      end
      if (acc) begin samp_q.push_back(samp_data); m_fill++; end
      if (start_n) begin n_starts++; m_send = 1; m_idx = 0; m_hdr = m_freq; end
      if (freq_valid) m_freq = wave_freq;
    end
  end

  task automatic step();
    @(posedge clk_125m);
    #1;
  endtask

  task automatic write_samples(input int n, input int mode, output int last_cyc);
    for (int i = 0; i < n; i++) begin
      samp_valid = 1'b1;
      samp_data  = (mode == 0) ? 8'(i) : 8'(i * 7 + 3);
      last_cyc   = cyc;
      step();
    end
    samp_valid = 1'b0;
  endtask

  task automatic wait_start(input string nm, output int seen_cyc);
    int k = 0;
    while (!tx_start_en && k < 3000) begin step(); k++; end
    n_checks++;
    if (!tx_start_en) $display("FAIL %s_start: tx_start_en=0 after 3000 cycles, required 1", nm);
    else n_pass++;
    seen_cyc = cyc;
  endtask

  task automatic serve_frame(input string nm, input int n_req, input int freq_at, input bit fill_chk,
                             input bit give_done, output int done_cyc,
                             output logic [7:0] b1, output logic [7:0] b2, output logic [7:0] b3);
    logic [7:0] e;
    done_cyc = 0; b1 = 0; b2 = 0; b3 = 0;
    step();
    for (int j = 0; j < n_req; j++) begin
      udp_tx_req = 1'b1;
      freq_valid = (j == freq_at);
      if (j == freq_at) wave_freq = 16'h5678;
      step();
      n_checks++;
      if (exp_q.size() == 0) $display("FAIL %s_byte%0d: data=%h, no byte expected", nm, j, udp_tx_data);
      else begin
        e = exp_q.pop_front();
        if (udp_tx_data !== e) $display("FAIL %s_byte%0d: data=%h required %h", nm, j, udp_tx_data, e);
        else n_pass++;
      end
      if (j == 1) b1 = udp_tx_data;
      if (j == 2) b2 = udp_tx_data;
      if (j == 3) b3 = udp_tx_data;
      if (fill_chk && j % 200 == 100 && j <= 900) begin
        n_checks++;
        if (fill_cnt !== 12'(m_fill)) $display("FAIL %s_fill%0d: fill_cnt=%0d required %0d", nm, j, fill_cnt, m_fill);
        else n_pass++;
      end
    end
    udp_tx_req = 1'b0;
    freq_valid = 1'b0;
    if (give_done) begin
      udp_tx_done = 1'b1;
      done_cyc = cyc;
      step();
      udp_tx_done = 1'b0;
    end
  endtask

  task automatic test_reset();
    repeat (3) step();
    n_checks++;
    if ({tx_start_en, tx_byte_num, udp_tx_data, fill_cnt, ovf_cnt, to_cnt} !== '0)
      $display("FAIL reset_outputs: start=%b num=%0d data=%h fill=%0d ovf=%0d to=%0d required all 0",
               tx_start_en, tx_byte_num, udp_tx_data, fill_cnt, ovf_cnt, to_cnt);
    else n_pass++;
    rst = 1'b0;
    step();
    n_checks++;
    if (tx_byte_num !== 16'd1028) $display("FAIL reset_bytenum: tx_byte_num=%0d required 1028", tx_byte_num);
    else n_pass++;
    udp_tx_req = 1'b1;
    step();
    udp_tx_req = 1'b0;
    n_checks++;
    if (udp_tx_data !== 8'h00 || fill_cnt !== '0)
      $display("FAIL stray_req: data=%h fill=%0d required 00 and 0", udp_tx_data, fill_cnt);
    else n_pass++;
    void'(exp_q.pop_front());
  endtask

  task automatic test_first_frame();
    int lc, sc, dc; logic [7:0] b1, b2, b3;
    freq_valid = 1'b1; wave_freq = 16'h1234;
    step();
    freq_valid = 1'b0;
    write_samples(PL, 0, lc);
    wait_start("first", sc);
    n_checks++;
    if (sc - lc != 2) $display("FAIL first_latency: start after %0d clocks required 2", sc - lc);
    else n_pass++;
    n_checks++;
    if (tx_byte_num !== 16'd1028) $display("FAIL first_bytenum: tx_byte_num=%0d required 1028", tx_byte_num);
    else n_pass++;
    serve_frame("first", FL, -1, 0, 1, dc, b1, b2, b3);
    n_checks++;
    if ({b1, b2, b3} !== 24'h001234) $display("FAIL first_header: got %h required 001234", {b1, b2, b3});
    else n_pass++;
    repeat (4) step();
    n_checks++;
    if (fill_cnt !== '0 || n_starts != 1) $display("FAIL first_after: fill=%0d starts=%0d required 0 and 1", fill_cnt, n_starts);
    else n_pass++;
  endtask

  task automatic test_overflow();
    int lc, sc, dc, s0; logic [7:0] b1, b2, b3;
    s0 = n_starts;
    write_samples(2100, 1, lc);
    step();
    n_checks++;
    if (fill_cnt !== 12'd2048 || ovf_cnt !== 8'd52 || n_starts - s0 != 1)
      $display("FAIL overflow: fill=%0d ovf=%0d starts=%0d required 2048, 52, 1", fill_cnt, ovf_cnt, n_starts - s0);
    else n_pass++;
    serve_frame("ovf_a", FL, -1, 0, 1, dc, b1, b2, b3);
    n_checks++;
    if (b1 !== 8'd1) $display("FAIL ovf_a_seq: seq=%0d required 1", b1);
    else n_pass++;
    wait_start("ovf_b", sc);
    n_checks++;
    if (sc - dc != 2) $display("FAIL ovf_b_latency: start after %0d clocks required 2", sc - dc);
    else n_pass++;
    serve_frame("ovf_b", FL, -1, 0, 1, dc, b1, b2, b3);
  endtask

  task automatic test_freq_change();
    int lc, sc, dc; logic [7:0] b1, b2, b3;
    write_samples(PL, 0, lc);
    wait_start("frq_a", sc);
    serve_frame("frq_a", FL, 50, 0, 1, dc, b1, b2, b3);
    n_checks++;
    if ({b2, b3} !== 16'h1234) $display("FAIL frq_a_header: got %h required 1234", {b2, b3});
    else n_pass++;
    write_samples(PL, 1, lc);
    wait_start("frq_b", sc);
    serve_frame("frq_b", FL, -1, 0, 1, dc, b1, b2, b3);
    n_checks++;
    if ({b2, b3} !== 16'h5678) $display("FAIL frq_b_header: got %h required 5678", {b2, b3});
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int lc, sc, dc; logic [7:0] b1, b2, b3;
    fork
      write_samples(2 * PL, 0, lc);
      begin
        wait_start("b2b_a", sc);
        serve_frame("b2b_a", FL, -1, 1, 1, dc, b1, b2, b3);
      end
    join
    wait_start("b2b_b", sc);
    n_checks++;
    if (sc - dc != 2) $display("FAIL b2b_latency: start after %0d clocks required 2", sc - dc);
    else n_pass++;
    serve_frame("b2b_b", FL, -1, 0, 1, dc, b1, b2, b3);
  endtask

  task automatic test_timeout();
    int lc, sc, dc, s0; logic [7:0] b1, b2, b3;
    write_samples(PL, 1, lc);
    wait_start("to_a", sc);
    serve_frame("to_a", FL, -1, 0, 0, dc, b1, b2, b3);
    n_checks++;
    if (b1 !== 8'd7) $display("FAIL to_a_seq: seq=%0d required 7", b1);
    else n_pass++;
    s0 = n_starts;
    repeat (TO - 1) step();
    n_checks++;
    if (to_cnt !== 8'd0) $display("FAIL to_early: to_cnt=%0d required 0", to_cnt);
    else n_pass++;
    step();
    n_checks++;
    if (to_cnt !== 8'd1) $display("FAIL to_count: to_cnt=%0d required 1", to_cnt);
    else n_pass++;
    repeat (5) step();
    write_samples(PL, 0, lc);
    wait_start("to_b", sc);
    n_checks++;
    if (sc - lc != 2 || n_starts - s0 != 0) $display("FAIL to_idle: latency=%0d starts=%0d required 2 and 0", sc - lc, n_starts - s0);
    else n_pass++;
    serve_frame("to_b", FL, -1, 0, 1, dc, b1, b2, b3);
    n_checks++;
    if (b1 !== 8'd7) $display("FAIL to_b_seq: seq=%0d required 7", b1);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int lc, sc, dc, s0; logic [7:0] b1, b2, b3;
    write_samples(PL, 1, lc);
    wait_start("rst_a", sc);
    serve_frame("rst_a", 100, -1, 0, 0, dc, b1, b2, b3);
    rst = 1'b1;
    step();
    n_checks++;
    if ({tx_start_en, tx_byte_num, udp_tx_data, fill_cnt, ovf_cnt, to_cnt} !== '0)
      $display("FAIL rst_outputs: start=%b num=%0d data=%h fill=%0d ovf=%0d to=%0d required all 0",
               tx_start_en, tx_byte_num, udp_tx_data, fill_cnt, ovf_cnt, to_cnt);
    else n_pass++;
    rst = 1'b0;
    s0 = n_starts;
    write_samples(PL - 1, 0, lc);
    repeat (6) step();
    n_checks++;
    if (n_starts != s0 || fill_cnt !== 12'd1023) $display("FAIL rst_nostart: starts=%0d fill=%0d required 0 and 1023", n_starts - s0, fill_cnt);
    else n_pass++;
    write_samples(1, 0, lc);
    wait_start("rst_b", sc);
    n_checks++;
    if (sc - lc != 2) $display("FAIL rst_latency: start after %0d clocks required 2", sc - lc);
    else n_pass++;
    serve_frame("rst_b", FL, -1, 0, 1, dc, b1, b2, b3);
    n_checks++;
    if ({b1, b2, b3} !== 24'h000000) $display("FAIL rst_header: got %h required 000000", {b1, b2, b3});
    else n_pass++;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_first_frame();
    test_overflow();
    test_freq_change();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
